// File: rtl/tail_lamp_controller.sv
// Thunderbird-style rear cluster controller: three lamps per side, a sequential
// inside-to-outside sweep for turn requests and an all-lamp flash for hazard.
// Lamp state advances once per animation step of STEP_CYCLES clocks.
module tail_lamp_controller #(
  parameter int STEP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       turn_left,
  input  logic       turn_right,
  input  logic       emergency,
  output logic [2:0] left_indicator_lamp,
  output logic [2:0] right_indicator_lamp
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    HAZ  = 3'd7
  } state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic          tick;
  logic          hazard_req;
  logic          in_sweep;
  logic          override;
  logic [2:0]    left_nxt, right_nxt;

  // Both turn levels together are treated exactly like the hazard switch.
  assign hazard_req = emergency | (turn_left & turn_right);
  assign tick       = (cnt == CNT_LAST);
  assign in_sweep   = (state != IDLE) && (state != HAZ);
  // Hazard cuts a sweep short immediately, without waiting for a step boundary.
  assign override   = in_sweep && hazard_req;

  // Step counter: wraps on tick, restarts when hazard pre-empts a sweep.
  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (override || tick) cnt <= '0;
    else                       cnt <= cnt + 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic: sweeps always run to completion unless hazard overrides.
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (tick) begin
        if (hazard_req)      nxt = HAZ;
        else if (turn_left)  nxt = L1;
        else if (turn_right) nxt = R1;
        else                 nxt = IDLE;
      end
      L1:  if (hazard_req) nxt = HAZ; else if (tick) nxt = L2;
      L2:  if (hazard_req) nxt = HAZ; else if (tick) nxt = L3;
      L3:  if (hazard_req) nxt = HAZ; else if (tick) nxt = IDLE;
      R1:  if (hazard_req) nxt = HAZ; else if (tick) nxt = R2;
      R2:  if (hazard_req) nxt = HAZ; else if (tick) nxt = R3;
      R3:  if (hazard_req) nxt = HAZ; else if (tick) nxt = IDLE;
      HAZ: if (tick) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Lamp decode of the upcoming state, so the lamp flops always mirror the state register.
  always_comb begin
    left_nxt  = 3'b000;
    right_nxt = 3'b000;
    case (nxt)
      L1:  left_nxt  = 3'b001;
      L2:  left_nxt  = 3'b011;
      L3:  left_nxt  = 3'b111;
      R1:  right_nxt = 3'b001;
      R2:  right_nxt = 3'b011;
      R3:  right_nxt = 3'b111;
      HAZ: begin
        left_nxt  = 3'b111;
        right_nxt = 3'b111;
      end
      default: ;
    endcase
  end

  // Registered lamp outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      left_indicator_lamp  <= 3'b000;
      right_indicator_lamp <= 3'b000;
    end else begin
      left_indicator_lamp  <= left_nxt;
      right_indicator_lamp <= right_nxt;
    end
  end

endmodule

// File: tb/tb_tail_lamp_controller.sv
// Bench for tail_lamp_controller: two instances (step 1 and step 3) share the
// stimulus; a mode/position reference model predicts both lamp sets each cycle.
module tb_tail_lamp_controller;

  logic clk = 1'b0;
  logic rst, turn_left, turn_right, emergency;
  logic [2:0] l1_lamp, r1_lamp, l3_lamp, r3_lamp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tail_lamp_controller #(.STEP_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .turn_left(turn_left), .turn_right(turn_right),
    .emergency(emergency), .left_indicator_lamp(l1_lamp), .right_indicator_lamp(r1_lamp));

  tail_lamp_controller #(.STEP_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .turn_left(turn_left), .turn_right(turn_right),
    .emergency(emergency), .left_indicator_lamp(l3_lamp), .right_indicator_lamp(r3_lamp));

  // Model: mode 0 off, 1 left sweep, 2 right sweep, 3 hazard on; pos = lit lamps in sweep.
  int steps [2] = '{1, 3};
  int m_mode [2];
  int m_pos  [2];
  int m_cnt  [2];

  function automatic logic [2:0] bar(input int n);
    logic [2:0] v;
    v = 3'b000;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [2:0] exp_left(input int k);
    if (m_mode[k] == 1) return bar(m_pos[k]);
    if (m_mode[k] == 3) return 3'b111;
    return 3'b000;
  endfunction

  function automatic logic [2:0] exp_right(input int k);
    if (m_mode[k] == 2) return bar(m_pos[k]);
    if (m_mode[k] == 3) return 3'b111;
    return 3'b000;
  endfunction

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit hz;
    hz = emergency || (turn_left && turn_right);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_mode[k] = 0; m_pos[k] = 0; m_cnt[k] = 0;
      end else if ((m_mode[k] == 1 || m_mode[k] == 2) && hz) begin
        m_mode[k] = 3; m_cnt[k] = 0;
      end else if (m_cnt[k] == steps[k] - 1) begin
        m_cnt[k] = 0;
        case (m_mode[k])
          0: begin
            if (hz)              m_mode[k] = 3;
            else if (turn_left)  begin m_mode[k] = 1; m_pos[k] = 1; end
            else if (turn_right) begin m_mode[k] = 2; m_pos[k] = 1; end
          end
          1, 2: if (m_pos[k] == 3) m_mode[k] = 0; else m_pos[k]++;
          default: m_mode[k] = 0;
        endcase
      end else begin
        m_cnt[k]++;
      end
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk({tag, ".l1"}, l1_lamp, exp_left(0));
    chk({tag, ".r1"}, r1_lamp, exp_right(0));
    chk({tag, ".l3"}, l3_lamp, exp_left(1));
    chk({tag, ".r3"}, r3_lamp, exp_right(1));
  endtask

  task automatic drive(input logic r, input logic e, input logic tl, input logic tr);
    rst = r; emergency = e; turn_left = tl; turn_right = tr;
  endtask

  initial begin
    drive(1, 1, 1, 1);
    for (int k = 0; k < 2; k++) begin m_mode[k] = 0; m_pos[k] = 0; m_cnt[k] = 0; end
    @(negedge clk);
    cycle("rst");
    cycle("rst");
    chk("rst_const_l", l1_lamp, 3'b000);
    chk("rst_const_r", r1_lamp, 3'b000);

    // Left held, then right held, from idle.
    drive(0, 0, 1, 0);
    for (int i = 0; i < 12; i++) cycle("left_held");
    chk("left_held_seq", l1_lamp, 3'b000);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle("drain");
    drive(0, 0, 0, 1);
    for (int i = 0; i < 13; i++) cycle("right_held");
    drive(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle("drain");

    // Single-cycle pulse completes its sweep.
    drive(0, 0, 1, 0);
    cycle("pulse");
    drive(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) cycle("pulse_done");

    // Hazard by switch and by both turns.
    drive(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) cycle("haz_em");
    drive(0, 0, 1, 1);
    for (int i = 0; i < 8; i++) cycle("haz_both");
    drive(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle("drain");

    // Hazard override mid sweep on the step-1 instance (left = 011).
    drive(0, 0, 1, 0);
    while (l1_lamp != 3'b011 && checks < 2000) cycle("to_l2");
    drive(0, 1, 0, 0);
    cycle("override");
    chk("override_l", l1_lamp, 3'b111);
    chk("override_r", r1_lamp, 3'b111);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle("drain");

    // Reset in the middle of a sweep.
    drive(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle("pre_rst");
    drive(1, 0, 1, 0);
    cycle("mid_rst");
    chk("mid_rst_l", l1_lamp, 3'b000);
    drive(0, 0, 1, 0);
    for (int i = 0; i < 6; i++) cycle("post_rst");

    // Randomized held-level segments.
    for (int seg = 0; seg < 150; seg++) begin
      int sel, len;
      sel = $urandom_range(0, 99);
      len = $urandom_range(1, 12);
      if (sel < 3)       drive(1, 0, $urandom_range(0, 1), $urandom_range(0, 1));
      else if (sel < 15) drive(0, 1, $urandom_range(0, 1), $urandom_range(0, 1));
      else if (sel < 22) drive(0, 0, 1, 1);
      else if (sel < 50) drive(0, 0, 1, 0);
      else if (sel < 75) drive(0, 0, 0, 1);
      else               drive(0, 0, 0, 0);
      if (sel < 3) len = 1;
      for (int i = 0; i < len; i++) cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
